// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, data/lane widths,
// wait-counter width and the address-error helper.
package dmem_pkg;

   localparam int DATA_W = 32;
   localparam int LANE_W = 8;
   localparam int BE_W   = DATA_W / LANE_W;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_ACCESS = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   // A byte address is in error when it is not word aligned or lies beyond the RAM.
   function automatic logic addr_err(input logic [31:0] addr, input int addr_w);
      logic [31:0] hi_mask;
      hi_mask  = ~((32'd1 << (addr_w + 2)) - 32'd1);
      addr_err = (addr[1:0] != 2'b00) || ((addr & hi_mask) != 32'd0);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM with per-byte write enables; read data appears
// one edge after a read-enabled edge. Contents are never reset.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              re,
   input  logic [BE_W-1:0]   we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

   always_ff @(posedge clk) begin
      for (int i = 0; i < BE_W; i++) begin
         if (we[i]) begin
            mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
         end
      end
      if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one outstanding load/store, WAIT_CYC wait states,
// valid/ready request and response channels. Optional address checking: DMEM_ERR_EN.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_W   = 10,
   parameter int WAIT_CYC = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [31:0]       req_addr,
   input  logic [BE_W-1:0]   req_be,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam logic [CNT_W-1:0] WAIT_INIT = (WAIT_CYC == 0) ? '0 : CNT_W'(WAIT_CYC - 1);

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt;
   logic                accept;
   logic                req_err;

   logic                we_p0;
   logic                err_p0;
   logic [ADDR_W-1:0]   addr_p0;
   logic [BE_W-1:0]     be_p0;
   logic [DATA_W-1:0]   wdata_p0;

   logic [ADDR_W-1:0]   ram_addr;
   logic                ram_re;
   logic [BE_W-1:0]     ram_we;
   logic [DATA_W-1:0]   ram_q;

   assign accept = req_valid & req_ready;

`ifdef DMEM_ERR_EN
   assign req_err = addr_err(req_addr, ADDR_W);
`else
   logic unused_addr_bits;
   assign req_err          = 1'b0;
   assign unused_addr_bits = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_nxt = (WAIT_CYC == 0) ? S_ACCESS : S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt == '0) begin
               state_nxt = S_ACCESS;
            end
         end
         S_ACCESS: state_nxt = S_RESP;
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (accept) begin
         cnt <= WAIT_INIT;
      end else if (state == S_WAIT && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   // stage p0: request captured on accept, held for the whole transaction
   always_ff @(posedge clk) begin
      if (accept) begin
         we_p0    <= req_we;
         err_p0   <= req_err;
         addr_p0  <= req_addr[ADDR_W+1:2];
         be_p0    <= req_be;
         wdata_p0 <= req_wdata;
      end
   end

   // The read is launched on the edge entering ACCESS so the word is ready during ACCESS;
   // with no wait states that edge is the accept edge, hence the bypass from req_addr.
   assign ram_addr = (state == S_IDLE) ? req_addr[ADDR_W+1:2] : addr_p0;
   assign ram_re   = (state_nxt == S_ACCESS);
   assign ram_we   = (state == S_ACCESS && we_p0 && !err_p0) ? be_p0 : '0;

   dmem_array #(
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk   (clk),
      .re    (ram_re),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (wdata_p0),
      .rdata (ram_q)
   );

   // stage p1: response registered at the end of ACCESS, held through RESP
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_rdata <= '0;
      end else if (state == S_ACCESS) begin
         rsp_rdata <= (!we_p0 && !err_p0) ? ram_q : '0;
      end
   end

`ifdef DMEM_ERR_EN
   logic err_p1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_p1 <= 1'b0;
      end else if (state == S_ACCESS) begin
         err_p1 <= err_p0;
      end
   end

   assign rsp_err = err_p1;
`else
   assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with an expected-response queue.
module tb_dmem_responder;

   localparam int ADDR_W   = 10;
   localparam int WAIT_CYC = 2;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [3:0]  req_be;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   dmem_responder #(
      .ADDR_W   (ADDR_W),
      .WAIT_CYC (WAIT_CYC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_be    (req_be),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request, wait for its response, optionally stall it, then complete it.
   task automatic run_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input int hold, input bit early_rdy);
      int          n;
      logic        acc;
      logic [31:0] held;
      exp_t        e;
      sb.push_back({exp_rdata, exp_err});
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_be    = be;
      req_wdata = wdata;
      rsp_ready = early_rdy;
      n   = 0;
      acc = 1'b0;
      while (!acc && n < 20) begin
         acc = req_ready;
         tick();
         n++;
      end
      check("accept_edges", n, 1);
      req_valid = 1'b0;
      check("busy_after_accept", req_ready, 1'b0);
      n = 0;
      while (!rsp_valid && n < 50) begin
         tick();
         n++;
      end
      check("latency", n, WAIT_CYC + 1);
      held = rsp_rdata;
      if (hold > 0) begin
         rsp_ready = 1'b0;
         req_valid = 1'b1;
         req_we    = 1'b0;
         req_addr  = 32'h10;
      end
      for (int i = 0; i < hold; i++) begin
         tick();
         check("stall_valid", rsp_valid, 1'b1);
         check("stall_rdata", rsp_rdata, held);
         check("stall_req_ready", req_ready, 1'b0);
      end
      rsp_ready = 1'b1;
      check("sb_nonempty", sb.size(), 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("rsp_rdata", rsp_rdata, e.rdata);
         check("rsp_err", rsp_err, e.err);
      end
      tick();
      rsp_ready = 1'b0;
      check("rsp_valid_clear", rsp_valid, 1'b0);
      check("ready_after_hs", req_ready, 1'b1);
      req_valid = 1'b0;
   endtask

   initial begin
      int bad;
      rst       = 1'b0;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'h10;
      req_be    = 4'hF;
      req_wdata = 32'hDEADBEEF;
      rsp_ready = 1'b0;

      // Reset held with a request pending
      repeat (3) tick();
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rsp_rdata", rsp_rdata, 32'h0);
      check("rst_rsp_err", rsp_err, 1'b0);
      tick();
      check("rst_no_accept", req_ready, 1'b1);
      rst = 1'b1;

      // Full-word store then load
      run_txn(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 0, 1'b0);
      run_txn(1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, 0, 1'b0);

      // Byte lanes, load stalled for five cycles
      run_txn(1'b1, 32'h10, 4'b0101, 32'h11223344, 32'h0, 1'b0, 0, 1'b0);
      run_txn(1'b0, 32'h10, 4'h0, 32'h0, 32'hDE22BE44, 1'b0, 5, 1'b0);

      // Empty byte mask writes nothing; rsp_ready held high from the start
      run_txn(1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, 32'h0, 1'b0, 0, 1'b0);
      run_txn(1'b0, 32'h10, 4'h0, 32'h0, 32'hDE22BE44, 1'b0, 0, 1'b1);

      // Reset during WAIT drops a store
      run_txn(1'b1, 32'h20, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, 0, 1'b0);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'h20;
      req_be    = 4'hF;
      req_wdata = 32'h12345678;
      tick();
      req_valid = 1'b0;
      check("midrst_busy", req_ready, 1'b0);
      tick();
      rst = 1'b0;
      #1;
      check("midrst_idle", req_ready, 1'b1);
      check("midrst_no_rsp", rsp_valid, 1'b0);
      #1;
      rst = 1'b1;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (rsp_valid !== 1'b0) bad++;
      end
      check("midrst_silent", bad, 0);
      run_txn(1'b0, 32'h20, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0, 0, 1'b0);

      // Out-of-range / misaligned addresses
      run_txn(1'b1, 32'h0, 4'hF, 32'h55AA55AA, 32'h0, 1'b0, 0, 1'b0);
`ifdef DMEM_ERR_EN
      run_txn(1'b0, 32'h22, 4'h0, 32'h0, 32'h0, 1'b1, 0, 1'b0);
      run_txn(1'b1, 32'h0000_1000, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b1, 0, 1'b0);
      run_txn(1'b0, 32'h0, 4'h0, 32'h0, 32'h55AA55AA, 1'b0, 0, 1'b0);
`else
      run_txn(1'b0, 32'h22, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0, 0, 1'b0);
`endif
      check("sb_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
